// File: rtl/arith_unit_seq.sv
// rtl/arith_unit_seq.sv - sign-magnitude add/sub/mul/div unit with a multi-cycle restoring divider
module arith_unit_seq #(
    parameter int W = 16
) (
    input  logic         clock,
    input  logic         reset,
    input  logic [W:0]   a,
    input  logic [W:0]   b,
    input  logic [1:0]   opcode,
    input  logic         start,
    input  logic         clear,
    output logic         busy,
    output logic         done,
    output logic [W:0]   answer,
    output logic         ovw,
    output logic         dz
);

    localparam int CW = $clog2(W + 1);

    typedef enum logic {
        IDLE,
        DIV
    } state_t;

    state_t         state, state_next;
    logic [W:0]     answer_q, answer_n;
    logic           ovw_q, ovw_n;
    logic           dz_q, dz_n;
    logic           done_q, done_n;
    logic [CW-1:0]  counter_q, counter_n;
    logic [W-1:0]   rem_q, rem_n;
    logic [W-1:0]   quo_q, quo_n;
    logic [W-1:0]   divisor_q, divisor_n;
    logic           sign_q, sign_n;

    // Add/sub in two's complement with two guard bits so |a|+|b| cannot wrap.
    logic [W+1:0]   a_tc, b_tc, sum_tc, sum_mag;
    logic           as_ovf;
    logic [2*W-1:0] product;
    logic           mul_ovf;

    assign a_tc    = a[W] ? ({(W+2){1'b0}} - {2'b00, a[W-1:0]}) : {2'b00, a[W-1:0]};
    assign b_tc    = b[W] ? ({(W+2){1'b0}} - {2'b00, b[W-1:0]}) : {2'b00, b[W-1:0]};
    assign sum_tc  = (opcode == 2'b10) ? (a_tc - b_tc) : (a_tc + b_tc);
    assign sum_mag = sum_tc[W+1] ? ({(W+2){1'b0}} - sum_tc) : sum_tc;
    assign as_ovf  = |sum_mag[W+1:W];

    assign product = {{W{1'b0}}, a[W-1:0]} * {{W{1'b0}}, b[W-1:0]};
    assign mul_ovf = |product[2*W-1:W];

    // One restoring step: partial remainder never exceeds the divisor, so W bits hold it.
    logic [W:0]     rem_shift;
    logic [W-1:0]   rem_sub;
    logic           rem_ge;
    logic [W-1:0]   quo_step;

    assign rem_shift = {rem_q, quo_q[W-1]};
    assign rem_ge    = rem_shift >= {1'b0, divisor_q};
    assign rem_sub   = rem_shift[W-1:0] - divisor_q;
    assign quo_step  = {quo_q[W-2:0], rem_ge};

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            answer_q  <= '0;
            ovw_q     <= 1'b0;
            dz_q      <= 1'b0;
            done_q    <= 1'b0;
            counter_q <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            divisor_q <= '0;
            sign_q    <= 1'b0;
        end else begin
            state     <= state_next;
            answer_q  <= answer_n;
            ovw_q     <= ovw_n;
            dz_q      <= dz_n;
            done_q    <= done_n;
            counter_q <= counter_n;
            rem_q     <= rem_n;
            quo_q     <= quo_n;
            divisor_q <= divisor_n;
            sign_q    <= sign_n;
        end
    end

    always_comb begin
        state_next = state;
        answer_n   = answer_q;
        ovw_n      = ovw_q;
        dz_n       = dz_q;
        done_n     = 1'b0;
        counter_n  = counter_q;
        rem_n      = rem_q;
        quo_n      = quo_q;
        divisor_n  = divisor_q;
        sign_n     = sign_q;

        case (state)
            IDLE: begin
                if (clear) begin
                    ovw_n = 1'b0;
                    dz_n  = 1'b0;
                end
                if (start) begin
                    case (opcode)
                        2'b00, 2'b10: begin
                            done_n = 1'b1;
                            if (as_ovf) begin
                                answer_n = '0;
                                ovw_n    = 1'b1;
                            end else begin
                                answer_n = {sum_tc[W+1] & (|sum_mag[W-1:0]), sum_mag[W-1:0]};
                            end
                        end
                        2'b01: begin
                            done_n = 1'b1;
                            if (mul_ovf) begin
                                answer_n = '0;
                                ovw_n    = 1'b1;
                            end else begin
                                answer_n = {(a[W] ^ b[W]) & (|product[W-1:0]), product[W-1:0]};
                            end
                        end
                        default: begin
                            if (b[W-1:0] == '0) begin
                                done_n   = 1'b1;
                                answer_n = '0;
                                ovw_n    = 1'b1;
                                dz_n     = 1'b1;
                            end else begin
                                rem_n      = '0;
                                quo_n      = a[W-1:0];
                                divisor_n  = b[W-1:0];
                                sign_n     = a[W] ^ b[W];
                                counter_n  = CW'(W);
                                state_next = DIV;
                            end
                        end
                    endcase
                end
            end
            DIV: begin
                rem_n     = rem_ge ? rem_sub : rem_shift[W-1:0];
                quo_n     = quo_step;
                counter_n = counter_q - 1'b1;
                if (counter_q == CW'(1)) begin
                    answer_n   = {sign_q & (|quo_step), quo_step};
                    done_n     = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign busy   = (state == DIV);
    assign done   = done_q;
    assign answer = answer_q;
    assign ovw    = ovw_q;
    assign dz     = dz_q;

endmodule

// File: tb/tb_arith_unit_seq.sv
// tb/tb_arith_unit_seq.sv - randomized bench for arith_unit_seq against an integer reference model
module tb_arith_unit_seq;

    localparam int W = 16;

    logic        clock;
    logic        reset;
    logic [W:0]  a, b;
    logic [1:0]  opcode;
    logic        start, clear;
    logic        busy, done, ovw, dz;
    logic [W:0]  answer;

    arith_unit_seq #(.W(W)) dut (
        .clock  (clock),
        .reset  (reset),
        .a      (a),
        .b      (b),
        .opcode (opcode),
        .start  (start),
        .clear  (clear),
        .busy   (busy),
        .done   (done),
        .answer (answer),
        .ovw    (ovw),
        .dz     (dz)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    int n_cmp = 0;
    int n_err = 0;
    bit checking = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Returns {overflow, divide_by_zero, answer}; result computed with signed integers.
    function automatic logic [W+2:0] ref_op(input logic [W:0] x, input logic [W:0] y,
                                           input logic [1:0] op);
        longint sx, sy, r, mag;
        logic [W:0] ans;
        sx = longint'(x[W-1:0]);
        sy = longint'(y[W-1:0]);
        if (x[W]) sx = -sx;
        if (y[W]) sy = -sy;
        case (op)
            2'b00: r = sx + sy;
            2'b01: r = sx * sy;
            2'b10: r = sx - sy;
            default: begin
                if (sy == 0) return {1'b1, 1'b1, {(W+1){1'b0}}};
                r = sx / sy;
            end
        endcase
        mag = (r < 0) ? -r : r;
        if (mag > longint'((1 << W) - 1)) return {1'b1, 1'b0, {(W+1){1'b0}}};
        ans = {(r < 0), mag[W-1:0]};
        return {1'b0, 1'b0, ans};
    endfunction

    // Model: a division is just "busy for W cycles, then deliver the precomputed quotient".
    logic [W:0] m_answer, m_pending;
    logic       m_ovw, m_dz, m_done;
    int         m_left;

    initial begin
        m_answer = '0; m_pending = '0; m_ovw = 1'b0; m_dz = 1'b0; m_done = 1'b0; m_left = 0;
    end

    always @(posedge clock) begin
        logic [W+2:0] r;
        r = ref_op(a, b, opcode);
        if (reset) begin
            m_answer <= '0; m_ovw <= 1'b0; m_dz <= 1'b0; m_done <= 1'b0; m_left <= 0;
        end else if (m_left != 0) begin
            m_left <= m_left - 1;
            m_done <= (m_left == 1);
            if (m_left == 1) m_answer <= m_pending;
        end else begin
            m_done <= 1'b0;
            if (start && opcode == 2'b11 && b[W-1:0] != '0) begin
                m_pending <= r[W:0];
                m_left    <= W;
                if (clear) begin m_ovw <= 1'b0; m_dz <= 1'b0; end
            end else if (start) begin
                m_answer <= r[W:0];
                m_ovw    <= (clear ? 1'b0 : m_ovw) | r[W+2];
                m_dz     <= (clear ? 1'b0 : m_dz) | r[W+1];
                m_done   <= 1'b1;
            end else if (clear) begin
                m_ovw <= 1'b0;
                m_dz  <= 1'b0;
            end
        end
    end

    always @(negedge clock) begin
        if (checking) begin
            check("busy",   32'(busy),   32'(m_left != 0));
            check("done",   32'(done),   32'(m_done));
            check("answer", 32'(answer), 32'(m_answer));
            check("ovw",    32'(ovw),    32'(m_ovw));
            check("dz",     32'(dz),     32'(m_dz));
        end
    end

    task automatic do_op(input logic [W:0] xa, input logic [W:0] xb, input logic [1:0] xo);
        @(negedge clock);
        a = xa; b = xb; opcode = xo; start = 1'b1;
        @(negedge clock);
        start = 1'b0;
    endtask

    task automatic pulse_clear();
        @(negedge clock);
        clear = 1'b1;
        @(negedge clock);
        clear = 1'b0;
    endtask

    function automatic logic [W:0] rand_operand();
        logic [W:0] v;
        case ($urandom_range(0, 3))
            0: v = (W+1)'($urandom);
            1: v = {1'($urandom), {(W-8){1'b0}}, 8'($urandom)};
            2: v = {1'($urandom), {W{1'b0}}};
            default: v = {1'($urandom), {(W-4){1'b1}}, 4'($urandom)};
        endcase
        return v;
    endfunction

    initial begin
        int cnt, busy_cnt;
        reset = 1'b1; a = '0; b = '0; opcode = 2'b00; start = 1'b0; clear = 1'b0;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        checking = 1'b1;
        check("reset_answer", 32'(answer), 32'h0);
        check("reset_busy",   32'(busy),   32'h0);
        check("reset_done",   32'(done),   32'h0);

        do_op({1'b0, 16'd100}, {1'b1, 16'd250}, 2'b00);
        check("add_done",   32'(done),   32'h1);
        check("add_answer", 32'(answer), 32'h10096);
        check("add_ovw",    32'(ovw),    32'h0);

        do_op({1'b0, 16'd65535}, {1'b0, 16'd1}, 2'b00);
        check("addovf_answer", 32'(answer), 32'h0);
        check("addovf_ovw",    32'(ovw),    32'h1);
        do_op({1'b0, 16'd2}, {1'b0, 16'd3}, 2'b01);
        check("mul6_answer", 32'(answer), 32'h6);
        check("mul6_ovw",    32'(ovw),    32'h1);
        pulse_clear();
        check("clear_ovw", 32'(ovw), 32'h0);

        do_op({1'b1, 16'd300}, {1'b0, 16'd200}, 2'b01);
        check("mulneg_answer", 32'(answer), 32'h1EA60);
        do_op({1'b0, 16'd300}, {1'b0, 16'd300}, 2'b01);
        check("mulovf_answer", 32'(answer), 32'h0);
        check("mulovf_ovw",    32'(ovw),    32'h1);
        pulse_clear();

        do_op({1'b1, 16'd1000}, {1'b0, 16'd7}, 2'b11);
        cnt = 1; busy_cnt = 0;
        while (!done && cnt < 40) begin
            if (busy) busy_cnt++;
            start  = (cnt == 5);
            opcode = (cnt == 5) ? 2'b00 : 2'b11;
            @(negedge clock);
            cnt++;
        end
        start = 1'b0;
        check("div_done_cycle", 32'(cnt),      32'd17);
        check("div_busy_len",   32'(busy_cnt), 32'd16);
        check("div_answer",     32'(answer),   32'h1008E);

        do_op({1'b0, 16'd5}, {1'b1, 16'd0}, 2'b11);
        check("dz_done",   32'(done),   32'h1);
        check("dz_busy",   32'(busy),   32'h0);
        check("dz_flag",   32'(dz),     32'h1);
        check("dz_ovw",    32'(ovw),    32'h1);
        check("dz_answer", 32'(answer), 32'h0);

        do_op({1'b0, 16'd1000}, {1'b0, 16'd7}, 2'b11);
        repeat (7) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        check("rst_busy",   32'(busy),   32'h0);
        check("rst_done",   32'(done),   32'h0);
        check("rst_answer", 32'(answer), 32'h0);
        repeat (10) @(negedge clock);
        check("rst_nodone", 32'(done), 32'h0);

        do_op({1'b1, 16'd5}, {1'b1, 16'd5}, 2'b10);
        check("negzero_answer", 32'(answer), 32'h0);
        check("negzero_done",   32'(done),   32'h1);

        for (int i = 0; i < 4000; i++) begin
            @(negedge clock);
            reset  = ($urandom_range(0, 499) == 0);
            start  = ($urandom_range(0, 2) == 0);
            clear  = ($urandom_range(0, 7) == 0);
            opcode = 2'($urandom);
            a      = rand_operand();
            b      = rand_operand();
        end
        @(negedge clock);
        reset = 1'b0; start = 1'b0; clear = 1'b0;
        cnt = 0;
        while (busy && cnt < 40) begin
            @(negedge clock);
            cnt++;
        end
        check("drain_idle", 32'(busy), 32'h0);
        @(negedge clock);
        checking = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
